// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if
//   StallBus bundle between the stage stall requesters and the central stall
//   scheduler.
//   Ports (signals):
//     stallreq_if      IF not ready (inst SRAM wait)
//     stallreq_id      ID load-use hazard
//     stallreq_ex      EX multi-cycle op in progress
//     stall[5:0]       [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB, 1=Stop
//     stall_src[1:0]   registered winning source
//     busy_cnt         consecutive EX_BUSY cycles, saturating
//     stall_timeout    sticky EX watchdog flag
//     perf_stall_cyc   cycles with any stall (zero unless perf counters built)
//     perf_bubble_cnt  load-use bubbles inserted (zero unless perf counters built)
//   Modports: master = requesters/observers, slave = stall scheduler.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 7
);
    logic             stallreq_if;
    logic             stallreq_id;
    logic             stallreq_ex;
    logic [5:0]       stall;
    logic [1:0]       stall_src;
    logic [CNT_W-1:0] busy_cnt;
    logic             stall_timeout;
    logic [31:0]      perf_stall_cyc;
    logic [31:0]      perf_bubble_cnt;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex,
        input  stall, stall_src, busy_cnt, stall_timeout,
               perf_stall_cyc, perf_bubble_cnt
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex,
        output stall, stall_src, busy_cnt, stall_timeout,
               perf_stall_cyc, perf_bubble_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
//   Central stall scheduler for the 5-stage core. Merges IF/ID/EX stall
//   requests into the StallBus (deepest requesting stage wins), records the
//   winner, counts consecutive EX-busy cycles and raises a sticky watchdog.
//   Optional performance counters are built when PIPE_STALL_PERF_EN is defined.
//   Ports:
//     clk   core clock, rising edge
//     rst   asynchronous reset, active-high
//     bus   pipe_stall_ctrl_if.slave (requests in, StallBus/status out)
//   Parameters:
//     EX_MAX_CYC  consecutive EX-busy cycles before the watchdog fires
//     CNT_W       busy counter width, must hold EX_MAX_CYC
//
//   state     | meaning
//   ----------+------------------------------------------
//   RUN       | no stall requested last cycle
//   IF_WAIT   | IF won last cycle (inst SRAM wait)
//   ID_BUBBLE | ID won last cycle (load-use bubble)
//   EX_BUSY   | EX won last cycle (multi-cycle ALU op)
module pipe_stall_ctrl #(
    parameter int EX_MAX_CYC = 64,
    parameter int CNT_W      = 7
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stall_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IF_WAIT   = 2'd1,
        ID_BUBBLE = 2'd2,
        EX_BUSY   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] EX_MAX  = CNT_W'(EX_MAX_CYC);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
    logic             timeout_q, timeout_d;
    logic [5:0]       stall_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            busy_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = RUN;
        stall_w    = 6'b000000;
        busy_cnt_d = '0;
        if (bus.stallreq_ex) begin
            state_d = EX_BUSY;
            stall_w = 6'b001111;
        end else if (bus.stallreq_id) begin
            state_d = ID_BUBBLE;
            stall_w = 6'b000111;
        end else if (bus.stallreq_if) begin
            state_d = IF_WAIT;
            stall_w = 6'b000011;
        end
        if (state_d == EX_BUSY) begin
            busy_cnt_d = (busy_cnt_q == CNT_MAX) ? busy_cnt_q : busy_cnt_q + CNT_W'(1);
        end
        // Watchdog only flags; the EX request keeps being obeyed.
        timeout_d = timeout_q | (busy_cnt_d == EX_MAX);
    end

    // Gated by rst so every stage is released the moment reset asserts.
    assign bus.stall         = rst ? 6'b000000 : stall_w;
    assign bus.stall_src     = state_q;
    assign bus.busy_cnt      = busy_cnt_q;
    assign bus.stall_timeout = timeout_q;

`ifdef PIPE_STALL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;

    always_comb begin
        perf_stall_d  = perf_stall_q;
        perf_bubble_d = perf_bubble_q;
        if (stall_w != 6'b000000) perf_stall_d  = perf_stall_q + 32'd1;
        if (state_d == ID_BUBBLE) perf_bubble_d = perf_bubble_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            perf_stall_q  <= perf_stall_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end

    assign bus.perf_stall_cyc  = perf_stall_q;
    assign bus.perf_bubble_cnt = perf_bubble_q;
`else
    assign bus.perf_stall_cyc  = 32'h0;
    assign bus.perf_bubble_cnt = 32'h0;
`endif
endmodule
